prime_candidate_search: RTL and testbench
=========================================

Name: prime_candidate_search

Overview:
Parametrised prime-search controller: assembles a WIDTH-bit random candidate from CHUNK-bit PRNG words, forces the required bits, and launches an external primality tester via a start/finish handshake. Retries with fresh candidates until the tester reports prime or MAX_TRIES is exhausted, then reports the result. One instance per key component (p, q, kappa) in key generation, sitting between a rand127 PRNG and a miller_rabin tester.

Parameters:
WIDTH, 272, candidate width in bits (any value >= 2; need not be a multiple of CHUNK)
CHUNK, 16, PRNG word width
MAX_TRIES, 1024, maximum candidates tested per search (>= 1)
TRY_W, 16, width of the try counter (must hold MAX_TRIES)
FORCE_MSB, 1, 1 = force cand[WIDTH-1]=1; 0 = leave the MSB random

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin search; sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a search
found  out  1  1 = prime_out holds a tested prime
prime_out  out  WIDTH  last prime found
tries  out  TRY_W  candidates launched in the current/last search
rand_in  in  CHUNK  free-running PRNG output, sampled in FILL
cand  out  WIDTH  candidate to tester; stable from LAUNCH through WAIT
test_start  out  1  one-cycle launch pulse to tester (its reset/start)
test_finish  in  1  tester result valid
test_prime  in  1  tester verdict, qualified by test_finish

Behaviour:
- NCHUNK = ceil(WIDTH/CHUNK). Chunk k occupies cand[k*CHUNK +: CHUNK]. For the last chunk, only the bits below WIDTH are kept; the upper rand_in bits are dropped.
- Reset, or any cycle in which reset is high:
  - state=IDLE, chunk counter=0.
  - busy=0, done=0, found=0, test_start=0, tries=0, cand=0, prime_out=0.
  - Reset takes priority over every other input. A mid-search reset abandons the search with no done pulse.
- IDLE:
  - start=1 -> FILL. Same edge: tries<=0, found<=0, chunk counter<=0.
  - test_finish is ignored.
- FILL:
  - One chunk is written per cycle from rand_in, in order 0..NCHUNK-1, so FILL lasts NCHUNK cycles.
  - On the cycle the last chunk is written, the forced bits are applied in the same register write: cand[0]=1, and cand[WIDTH-1]=1 if FORCE_MSB. Then -> LAUNCH.
- LAUNCH:
  - test_start=1 for exactly this cycle; tries<=tries+1; -> WAIT.
  - First test_start occurs NCHUNK+1 cycles after the start-sampling edge.
- WAIT:
  - cand is held. State is held until test_finish=1, then:
    - test_prime=1 -> prime_out<=cand, found<=1, -> DONE.
    - else if tries==MAX_TRIES -> found stays 0, prime_out unchanged, -> DONE.
    - else -> FILL with chunk counter<=0 (a fresh candidate is drawn).
  - A prime verdict on the MAX_TRIES-th attempt counts as found.
- DONE: done=1 for one cycle; -> IDLE.
- prime_out, found and tries hold their values in IDLE until the next accepted start.
- start is ignored while busy=1. test_finish is ignored outside WAIT.
- No timeout on test_finish; tester latency is unbounded.

Test Plan:
1. WIDTH=20, CHUNK=16, FORCE_MSB=1. start; rand_in=0x0002 then 0x0003; tester answers finish/prime=1 three cycles after test_start -> test_start at start+3 with cand=0xB0003; then done pulse, found=1, prime_out=0xB0003, tries=1.
2. MAX_TRIES=3; tester always returns prime=0 -> exactly 3 test_start pulses, each preceded by NCHUNK FILL cycles; done with found=0, tries=3, prime_out keeps its prior value.
3. Tester returns 0 then 1 -> second candidate latched; tries=2, found=1. With FORCE_MSB=0, rand 0x0002/0x0003 gives cand=0x30003.
4. Reset asserted in WAIT -> next cycle busy=0, test_start=0, found=0, prime_out=0, tries=0; a late test_finish=1 causes no state change and no done pulse.
5. start pulsed in FILL and WAIT -> ignored, tries unaffected. test_finish=1 in IDLE -> ignored. start and reset in the same cycle -> stays IDLE.
6. WIDTH=272 (17 chunks, exact multiple of CHUNK) -> 17 FILL cycles; cand[271] and cand[0] are 1; chunks land in order LSB-first.

Source files
------------

// File: rtl/prime_candidate_search_if.sv
// Handshake bundle between the prime search controller, its PRNG and tester.
// master drives the requests/tester replies, slave is the controller.
interface prime_candidate_search_if #(
  parameter int WIDTH = 272,
  parameter int CHUNK = 16,
  parameter int TRY_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] prime_out;
  logic [TRY_W-1:0] tries;
  logic [CHUNK-1:0] rand_in;
  logic [WIDTH-1:0] cand;
  logic             test_start;
  logic             test_finish;
  logic             test_prime;

  modport master (
    output start, rand_in, test_finish, test_prime,
    input  busy, done, found, prime_out, tries, cand, test_start
  );

  modport slave (
    input  start, rand_in, test_finish, test_prime,
    output busy, done, found, prime_out, tries, cand, test_start
  );
endinterface

// File: rtl/prime_candidate_search.sv
// Prime search controller: fills a random odd candidate chunk by chunk,
// launches the external tester and retries until prime or out of tries.
module prime_candidate_search #(
  parameter int WIDTH     = 272,
  parameter int CHUNK     = 16,
  parameter int MAX_TRIES = 1024,
  parameter int TRY_W     = 16,
  parameter int FORCE_MSB = 1
) (
  input logic clk,
  input logic reset,
  prime_candidate_search_if.slave bus
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int EXT_W  = NCHUNK * CHUNK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    chunk_q, chunk_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] prime_q, prime_d;
  logic             found_q, found_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [EXT_W-1:0] ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      chunk_q <= '0;
      cand_q  <= '0;
      prime_q <= '0;
      found_q <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      cand_q  <= cand_d;
      prime_q <= prime_d;
      found_q <= found_d;
      tries_q <= tries_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    cand_d  = cand_q;
    prime_d = prime_q;
    found_d = found_q;
    tries_d = tries_q;
    ext     = '0;
    ext[WIDTH-1:0] = cand_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FILL;
          tries_d = '0;
          found_d = 1'b0;
          chunk_d = '0;
        end
      end
      S_FILL: begin
        // Padding above WIDTH in ext swallows the dropped top bits.
        for (int k = 0; k < NCHUNK; k++) begin
          if (chunk_q == CW'(k)) ext[k*CHUNK +: CHUNK] = bus.rand_in;
        end
        cand_d = ext[WIDTH-1:0];
        if (chunk_q == CW'(NCHUNK - 1)) begin
          cand_d[0] = 1'b1;
          if (FORCE_MSB != 0) cand_d[WIDTH-1] = 1'b1;
          state_d = S_LAUNCH;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      S_LAUNCH: begin
        tries_d = tries_q + TRY_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.test_finish) begin
          if (bus.test_prime) begin
            prime_d = cand_q;
            found_d = 1'b1;
            state_d = S_DONE;
          end else if (tries_q == TRY_W'(MAX_TRIES)) begin
            state_d = S_DONE;
          end else begin
            chunk_d = '0;
            state_d = S_FILL;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE) & ~reset;
  assign bus.done       = (state_q == S_DONE) & ~reset;
  assign bus.test_start = (state_q == S_LAUNCH) & ~reset;
  assign bus.found      = found_q;
  assign bus.prime_out  = prime_q;
  assign bus.tries      = tries_q;
  assign bus.cand       = cand_q;
endmodule

// File: tb/tb_prime_candidate_search.sv
// Directed bench for prime_candidate_search: two 20-bit instances
// (MSB forced / not forced) and one 272-bit instance.
module tb_prime_candidate_search;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        start;
  logic [15:0] rnd;
  logic        fin, prm;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  prime_candidate_search_if #(.WIDTH(20),  .CHUNK(16), .TRY_W(16)) ia ();
  prime_candidate_search_if #(.WIDTH(20),  .CHUNK(16), .TRY_W(16)) ib ();
  prime_candidate_search_if #(.WIDTH(272), .CHUNK(16), .TRY_W(16)) ic ();

  assign ia.start = start;
  assign ia.rand_in = rnd;
  assign ia.test_finish = fin;
  assign ia.test_prime = prm;
  assign ib.start = start;
  assign ib.rand_in = rnd;
  assign ib.test_finish = fin;
  assign ib.test_prime = prm;
  assign ic.start = start;
  assign ic.rand_in = rnd;
  assign ic.test_finish = fin;
  assign ic.test_prime = prm;

  prime_candidate_search #(
    .WIDTH(20), .CHUNK(16), .MAX_TRIES(3), .TRY_W(16), .FORCE_MSB(1)
  ) ua (.clk(clk), .reset(rst_a), .bus(ia.slave));

  prime_candidate_search #(
    .WIDTH(20), .CHUNK(16), .MAX_TRIES(3), .TRY_W(16), .FORCE_MSB(0)
  ) ub (.clk(clk), .reset(rst_b), .bus(ib.slave));

  prime_candidate_search #(
    .WIDTH(272), .CHUNK(16), .MAX_TRIES(1), .TRY_W(16), .FORCE_MSB(1)
  ) uc (.clk(clk), .reset(rst_c), .bus(ic.slave));

  task automatic chk(input string tag, input logic [271:0] got,
                     input logic [271:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill2(input logic [15:0] r0, input logic [15:0] r1);
    rnd = r0;
    tick();
    rnd = r1;
    tick();
  endtask

  // Counts cycles until A launches, bounded so a stuck DUT cannot hang.
  task automatic wait_ts_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ia.test_start && n < 50);
  endtask

  logic [271:0] exp_c;
  int n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 0; rnd = '0; fin = 0; prm = 0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    tick(); tick();
    rst_a = 0; rst_b = 0;

    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_found", ia.found, 0);
    chk("rst_prime", ia.prime_out, 0);
    chk("rst_tries", ia.tries, 0);
    chk("rst_cand", ia.cand, 0);
    chk("rst_ts", ia.test_start, 0);

    // finish in IDLE is ignored
    fin = 1; prm = 1;
    tick();
    chk("idle_fin_busy", ia.busy, 0);
    chk("idle_fin_found", ia.found, 0);
    fin = 0; prm = 0;

    // start together with reset stays idle
    rst_a = 1; rst_b = 1; start = 1;
    tick();
    chk("rst_start_busy", ia.busy, 0);
    rst_a = 0; rst_b = 0; start = 0;
    tick();
    chk("rst_start_busy2", ia.busy, 0);

    // test 1: single prime; start held into FILL is ignored
    start = 1;
    tick();
    chk("t1_busy", ia.busy, 1);
    rnd = 16'h0002;
    tick();
    start = 0;
    chk("t1_ts_early", ia.test_start, 0);
    rnd = 16'h0003;
    tick();
    chk("t1_ts", ia.test_start, 1);
    chk("t1_cand_a", ia.cand, 20'hB0003);
    chk("t1_cand_b", ib.cand, 20'h30003);
    tick();
    chk("t1_ts_pulse", ia.test_start, 0);
    chk("t1_tries_wait", ia.tries, 1);
    start = 1;
    tick();
    start = 0;
    chk("t1_start_wait", ia.tries, 1);
    chk("t1_cand_hold", ia.cand, 20'hB0003);
    fin = 1; prm = 1;
    tick();
    fin = 0; prm = 0;
    chk("t1_done", ia.done, 1);
    chk("t1_found", ia.found, 1);
    chk("t1_prime_a", ia.prime_out, 20'hB0003);
    chk("t1_prime_b", ib.prime_out, 20'h30003);
    chk("t1_tries", ia.tries, 1);
    tick();
    chk("t1_done_pulse", ia.done, 0);
    chk("t1_idle", ia.busy, 0);
    tick();
    chk("t1_hold_prime", ia.prime_out, 20'hB0003);
    chk("t1_hold_found", ia.found, 1);

    // test 2: tester never says prime, MAX_TRIES=3
    rnd = 16'h7777;
    start = 1;
    tick();
    start = 0;
    chk("t2_found_clr", ia.found, 0);
    for (int t = 0; t < 3; t++) begin
      wait_ts_a(n);
      chk("t2_fill_cycles", n, 2);
      tick();
      chk("t2_tries", ia.tries, t + 1);
      fin = 1; prm = 0;
      tick();
      fin = 0;
      if (t < 2) chk("t2_retry_busy", ia.busy, 1);
    end
    chk("t2_done", ia.done, 1);
    chk("t2_found", ia.found, 0);
    chk("t2_tries_final", ia.tries, 3);
    chk("t2_prime_kept", ia.prime_out, 20'hB0003);
    tick();
    tick();
    chk("t2_no_more_ts", ia.test_start, 0);
    chk("t2_idle", ia.busy, 0);

    // test 3: fail then prime, second candidate latched
    start = 1;
    tick();
    start = 0;
    fill2(16'h1111, 16'h0005);
    chk("t3_cand1_a", ia.cand, 20'hD1111);
    chk("t3_cand1_b", ib.cand, 20'h51111);
    tick();
    fin = 1; prm = 0;
    tick();
    fin = 0;
    fill2(16'h0002, 16'h0003);
    chk("t3_ts2", ia.test_start, 1);
    chk("t3_cand2_b", ib.cand, 20'h30003);
    tick();
    fin = 1; prm = 1;
    tick();
    fin = 0; prm = 0;
    chk("t3_done", ib.done, 1);
    chk("t3_found", ib.found, 1);
    chk("t3_tries", ib.tries, 2);
    chk("t3_prime_b", ib.prime_out, 20'h30003);
    chk("t3_prime_a", ia.prime_out, 20'hB0003);
    tick();

    // test 4: reset during WAIT abandons search
    start = 1;
    tick();
    start = 0;
    fill2(16'h4321, 16'h0001);
    tick();
    chk("t4_busy", ia.busy, 1);
    rst_a = 1; rst_b = 1;
    tick();
    chk("t4_busy_rst", ia.busy, 0);
    chk("t4_ts_rst", ia.test_start, 0);
    chk("t4_found_rst", ia.found, 0);
    chk("t4_prime_rst", ia.prime_out, 0);
    chk("t4_tries_rst", ia.tries, 0);
    rst_a = 0;
    fin = 1; prm = 1;
    tick();
    fin = 0; prm = 0;
    chk("t4_late_done", ia.done, 0);
    chk("t4_late_busy", ia.busy, 0);
    chk("t4_late_found", ia.found, 0);

    // test 6: 272-bit, 17 chunks LSB first
    rst_a = 1;
    rst_c = 0;
    tick();
    exp_c = '0;
    for (int k = 0; k < 17; k++) exp_c[k*16 +: 16] = 16'h0100 + 16'(k);
    exp_c[0] = 1'b1;
    exp_c[271] = 1'b1;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 17; k++) begin
      if (k == 16) chk("t6_ts_early", ic.test_start, 0);
      rnd = 16'h0100 + 16'(k);
      tick();
    end
    chk("t6_ts", ic.test_start, 1);
    chk("t6_cand", ic.cand, exp_c);
    chk("t6_msb", ic.cand[271], 1);
    chk("t6_lsb_chunk", ic.cand[15:0], 16'h0101);
    tick();
    fin = 1; prm = 1;
    tick();
    fin = 0; prm = 0;
    chk("t6_done", ic.done, 1);
    chk("t6_found", ic.found, 1);
    chk("t6_prime", ic.prime_out, exp_c);
    chk("t6_tries", ic.tries, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
